// File: rtl/bp_pkg.sv
// bp_pkg: shared types and helpers for the branch predictor BTB.
//   - Direction counter values: weakly not-taken (01 when CTR_W=2) on reset and invalidation,
//     weakly taken (10 when CTR_W=2) on allocation.
//   - FSM state enum for the invalidation sweep.
//   - Saturating increment/decrement helpers used by bp_sat_ctr.
package bp_pkg;

    typedef enum logic {BP_IDLE, BP_SWEEP} bp_state_e;

    function automatic int ctr_rst_val(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int ctr_alloc_val(input int w);
        return 1 << (w - 1);
    endfunction

    function automatic int sat_inc(input int v, input int w);
        return (v >= (1 << w) - 1) ? v : v + 1;
    endfunction

    function automatic int sat_dec(input int v);
        return (v == 0) ? 0 : v - 1;
    endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// bp_sat_ctr: W-bit saturating up/down direction counter with clear and load.
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset (resets to weakly not-taken)
//   clear         return to weakly not-taken (highest priority)
//   load          load weakly taken (allocation)
//   inc, dec      saturating +1 / -1 (inc wins if both are high)
//   q             counter value
module bp_sat_ctr
    import bp_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         load,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] RST   = W'(ctr_rst_val(W));
    localparam logic [W-1:0] ALLOC = W'(ctr_alloc_val(W));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  q <= RST;
        else if (clear) q <= RST;
        else if (load)  q <= ALLOC;
        else if (inc)   q <= W'(sat_inc(int'(q), W));
        else if (dec)   q <= W'(sat_dec(int'(q)));
    end

endmodule

// File: rtl/branch_predictor_btb.sv
// branch_predictor_btb: direct-mapped branch target buffer with per-entry saturating
// direction counters. Lookup is combinational (zero latency); training via one update port;
// inv_req starts a one-entry-per-cycle invalidation sweep.
// Optional feature macro: BP_STATS_EN (update / mispredict counters; tied to 0 when undefined).
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   lookup_pc                    IF-stage PC
//   pred_taken, pred_next_pc     prediction (target on taken, else lookup_pc+4)
//   upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict   ID-stage training
//   inv_req, busy                invalidate request pulse, sweep in progress
//   stat_updates, stat_mispred   accepted update / mispredict counts
module branch_predictor_btb
    import bp_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    parameter int CTR_W   = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_next_pc,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_mispredict,
    input  logic            inv_req,
    output logic            busy,
    output logic [31:0]     stat_updates,
    output logic [31:0]     stat_mispred
);

    localparam int IDX_W = $clog2(ENTRIES);

    logic [ENTRIES-1:0]             valid;
    logic [TAG_W-1:0]               tags    [ENTRIES];
    logic [XLEN-1:0]                targets [ENTRIES];
    logic [ENTRIES-1:0][CTR_W-1:0]  ctr_q;
    bp_state_e                      state, state_next;
    logic [IDX_W-1:0]               sweep_idx;

    logic [IDX_W-1:0] li, ui;
    logic [TAG_W-1:0] lt, ut;
    logic             sweeping, accept, upd_hit, alloc;

    assign li = lookup_pc[IDX_W+1:2];
    assign lt = lookup_pc[IDX_W+2 +: TAG_W];
    assign ui = upd_pc[IDX_W+1:2];
    assign ut = upd_pc[IDX_W+2 +: TAG_W];

    assign sweeping = (state == BP_SWEEP);
    // A same-cycle inv_req drops the update; nothing trains during a sweep.
    assign accept   = !sweeping && upd_valid && !inv_req;
    assign upd_hit  = valid[ui] && (tags[ui] == ut);
    assign alloc    = accept && upd_taken && !upd_hit;

    always_comb begin
        state_next = state;
        if (sweeping) state_next = (sweep_idx == IDX_W'(ENTRIES - 1)) ? BP_IDLE : BP_SWEEP;
        else          state_next = inv_req ? BP_SWEEP : BP_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= BP_IDLE;
            sweep_idx <= '0;
        end else begin
            state     <= state_next;
            sweep_idx <= sweeping ? sweep_idx + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     valid <= '0;
        else if (sweeping) valid[sweep_idx] <= 1'b0;
        else if (alloc)    valid[ui] <= 1'b1;
    end

    // Tag rewrite on a taken hit is harmless (same value); target follows the latest taken outcome.
    always_ff @(posedge clk) begin
        if (accept && upd_taken) begin
            tags[ui]    <= ut;
            targets[ui] <= upd_target;
        end
    end

    for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
        logic sel;
        assign sel = (ui == IDX_W'(g));
        bp_sat_ctr #(.W(CTR_W)) u_ctr (
            .clk     (clk),
            .reset_n (reset_n),
            .clear   (sweeping && sweep_idx == IDX_W'(g)),
            .load    (alloc && sel),
            .inc     (accept && sel && upd_hit && upd_taken),
            .dec     (accept && sel && upd_hit && !upd_taken),
            .q       (ctr_q[g])
        );
    end

    assign busy         = sweeping;
    assign pred_taken   = !sweeping && valid[li] && (tags[li] == lt) && ctr_q[li][CTR_W-1];
    assign pred_next_pc = pred_taken ? targets[li] : lookup_pc + XLEN'(4);

`ifdef BP_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_updates <= '0;
            stat_mispred <= '0;
        end else if (accept) begin
            stat_updates <= stat_updates + 32'd1;
            stat_mispred <= stat_mispred + 32'(upd_mispredict);
        end
    end
    logic unused_bits;
    assign unused_bits = ^{upd_pc[1:0], upd_pc[XLEN-1:IDX_W+2+TAG_W], ctr_q};
`else
    assign stat_updates = '0;
    assign stat_mispred = '0;
    logic unused_bits;
    assign unused_bits = ^{upd_pc[1:0], upd_pc[XLEN-1:IDX_W+2+TAG_W], ctr_q, upd_mispredict};
`endif

endmodule

// File: tb/tb_branch_predictor_btb.sv
// tb_branch_predictor_btb: directed self-checking bench for branch_predictor_btb
// (ENTRIES=16, TAG_W=8: idx=pc[5:2], tag=pc[13:6]). Stats checks follow BP_STATS_EN.
module tb_branch_predictor_btb;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] lookup_pc;
    logic        pred_taken;
    logic [31:0] pred_next_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;
    logic        inv_req;
    logic        busy;
    logic [31:0] stat_updates;
    logic [31:0] stat_mispred;

    int n_checks = 0;
    int n_fail   = 0;

    branch_predictor_btb dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .lookup_pc      (lookup_pc),
        .pred_taken     (pred_taken),
        .pred_next_pc   (pred_next_pc),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_mispredict (upd_mispredict),
        .inv_req        (inv_req),
        .busy           (busy),
        .stat_updates   (stat_updates),
        .stat_mispred   (stat_mispred)
    );

    always #5 clk = ~clk;

    // One update, driven at a falling edge and captured by the next rising edge.
    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic mis);
        @(negedge clk);
        upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt; upd_mispredict = mis;
        @(negedge clk);
        upd_valid = 1'b0; upd_mispredict = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; lookup_pc = 32'h40; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
        upd_target = '0; upd_mispredict = 1'b0; inv_req = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({pred_taken, pred_next_pc, busy} !== {1'b0, 32'h44, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got taken=%b next=%h busy=%b want 0/00000044/0", pred_taken, pred_next_pc, busy);
        end
        n_checks++;
        if ({stat_updates, stat_mispred} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_stats: got %0d/%0d want 0/0", stat_updates, stat_mispred);
        end
        reset_n = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if ({pred_taken, pred_next_pc} !== {1'b0, 32'h44}) begin
            n_fail++;
            $display("FAIL reset_release: got %b/%h want 0/00000044", pred_taken, pred_next_pc);
        end
    endtask

    task automatic test_train;
        logic        tk  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic        ept [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] enp [6] = '{32'h100, 32'h44, 32'h44, 32'h44, 32'h44, 32'h100};
        lookup_pc = 32'h40;
        for (int i = 0; i < 6; i++) begin
            upd(32'h40, tk[i], 32'h100, 1'b0);
            #1;
            n_checks++;
            if ({pred_taken, pred_next_pc} !== {ept[i], enp[i]}) begin
                n_fail++;
                $display("FAIL train_step%0d: got %b/%h want %b/%h", i, pred_taken, pred_next_pc, ept[i], enp[i]);
            end
        end
    endtask

    task automatic test_same_cycle;
        @(negedge clk);
        lookup_pc = 32'h80;
        upd_valid = 1'b1; upd_pc = 32'h80; upd_taken = 1'b1; upd_target = 32'h300;
        #1;
        n_checks++;
        if ({pred_taken, pred_next_pc} !== {1'b0, 32'h84}) begin
            n_fail++;
            $display("FAIL same_cycle_old: got %b/%h want 0/00000084", pred_taken, pred_next_pc);
        end
        @(negedge clk);
        upd_valid = 1'b0;
        #1;
        n_checks++;
        if ({pred_taken, pred_next_pc} !== {1'b1, 32'h300}) begin
            n_fail++;
            $display("FAIL same_cycle_next: got %b/%h want 1/00000300", pred_taken, pred_next_pc);
        end
    endtask

    task automatic test_alias;
        lookup_pc = 32'h440; #1;
        n_checks++;
        if ({pred_taken, pred_next_pc} !== {1'b0, 32'h444}) begin
            n_fail++;
            $display("FAIL alias_miss: got %b/%h want 0/00000444", pred_taken, pred_next_pc);
        end
        upd(32'h440, 1'b1, 32'h200, 1'b1);
        lookup_pc = 32'h40; #1;
        n_checks++;
        if ({pred_taken, pred_next_pc} !== {1'b0, 32'h44}) begin
            n_fail++;
            $display("FAIL alias_evicted: got %b/%h want 0/00000044", pred_taken, pred_next_pc);
        end
        lookup_pc = 32'h440; #1;
        n_checks++;
        if ({pred_taken, pred_next_pc} !== {1'b1, 32'h200}) begin
            n_fail++;
            $display("FAIL alias_replaced: got %b/%h want 1/00000200", pred_taken, pred_next_pc);
        end
    endtask

    // 10 -> 11 -> 11 -> 11 (saturate), then 10 (still taken), then 01 (not taken), then 10.
    task automatic test_saturate;
        logic        tk  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic        ept [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [31:0] enp [6] = '{32'h200, 32'h200, 32'h200, 32'h200, 32'h444, 32'h200};
        lookup_pc = 32'h440;
        for (int i = 0; i < 6; i++) begin
            upd(32'h440, tk[i], 32'h200, 1'b0);
            #1;
            n_checks++;
            if ({pred_taken, pred_next_pc} !== {ept[i], enp[i]}) begin
                n_fail++;
                $display("FAIL saturate_step%0d: got %b/%h want %b/%h", i, pred_taken, pred_next_pc, ept[i], enp[i]);
            end
        end
    endtask

    task automatic test_sweep;
        logic [31:0] su, sm;
        logic [31:0] pcs [5] = '{32'h40, 32'h440, 32'h80, 32'hC0, 32'h100};
        int n = 0;
        su = stat_updates; sm = stat_mispred;
        @(negedge clk);
        inv_req = 1'b1;
        upd_valid = 1'b1; upd_pc = 32'hC0; upd_taken = 1'b1; upd_target = 32'h500;
        #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep_not_yet_busy: got %b want 0", busy);
        end
        @(negedge clk);
        inv_req = 1'b0; upd_valid = 1'b0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            if (n == 2) begin
                upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h600;
                lookup_pc = 32'h80;
                #1;
                n_checks++;
                if ({pred_taken, pred_next_pc} !== {1'b0, 32'h84}) begin
                    n_fail++;
                    $display("FAIL sweep_fallthrough: got %b/%h want 0/00000084", pred_taken, pred_next_pc);
                end
            end
            if (n == 3) begin
                upd_valid = 1'b0; inv_req = 1'b1;
            end
            if (n == 4) inv_req = 1'b0;
            @(negedge clk);
        end
        n_checks++;
        if (n !== 16) begin
            n_fail++;
            $display("FAIL sweep_busy_cycles: got %0d want 16", n);
        end
        for (int i = 0; i < 5; i++) begin
            lookup_pc = pcs[i]; #1;
            n_checks++;
            if ({pred_taken, pred_next_pc} !== {1'b0, pcs[i] + 32'd4}) begin
                n_fail++;
                $display("FAIL sweep_after_miss pc=%h: got %b/%h want 0/%h", pcs[i], pred_taken, pred_next_pc, pcs[i] + 32'd4);
            end
        end
        n_checks++;
        if ({stat_updates, stat_mispred} !== {su, sm}) begin
            n_fail++;
            $display("FAIL sweep_stats: got %0d/%0d want %0d/%0d", stat_updates, stat_mispred, su, sm);
        end
    endtask

    task automatic test_back_to_back;
        upd(32'h80, 1'b1, 32'h300, 1'b0);
        upd(32'hFFFF_FFFC, 1'b1, 32'h700, 1'b0);
        lookup_pc = 32'h80; #1;
        n_checks++;
        if ({pred_taken, pred_next_pc} !== {1'b1, 32'h300}) begin
            n_fail++;
            $display("FAIL b2b_realloc: got %b/%h want 1/00000300", pred_taken, pred_next_pc);
        end
        lookup_pc = 32'hFFFF_FFFC; #1;
        n_checks++;
        if ({pred_taken, pred_next_pc} !== {1'b1, 32'h700}) begin
            n_fail++;
            $display("FAIL b2b_high_pc: got %b/%h want 1/00000700", pred_taken, pred_next_pc);
        end
        lookup_pc = 32'hFFFF_FFF8; #1;
        n_checks++;
        if ({pred_taken, pred_next_pc} !== {1'b0, 32'hFFFF_FFFC}) begin
            n_fail++;
            $display("FAIL b2b_miss_neighbour: got %b/%h want 0/fffffffc", pred_taken, pred_next_pc);
        end
        upd(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0);
        lookup_pc = 32'hFFFF_FFFC; #1;
        n_checks++;
        if ({pred_taken, pred_next_pc} !== {1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL pc_wrap: got %b/%h want 0/00000000", pred_taken, pred_next_pc);
        end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        inv_req = 1'b1;
        @(negedge clk);
        inv_req = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_busy: got %b want 0", busy);
        end
        @(negedge clk);
        reset_n = 1'b1;
        lookup_pc = 32'h80;
        @(negedge clk); #1;
        n_checks++;
        if ({busy, pred_taken, pred_next_pc} !== {1'b0, 1'b0, 32'h84}) begin
            n_fail++;
            $display("FAIL async_reset_after: got busy=%b %b/%h want 0 0/00000084", busy, pred_taken, pred_next_pc);
        end
    endtask

    task automatic test_stats;
        logic [31:0] eu, em;
        upd(32'h40, 1'b1, 32'h100, 1'b1);
        upd(32'h40, 1'b1, 32'h100, 1'b0);
        upd(32'h80, 1'b0, 32'h0,   1'b0);
`ifdef BP_STATS_EN
        eu = 32'd3; em = 32'd1;
`else
        eu = 32'd0; em = 32'd0;
`endif
        #1;
        n_checks++;
        if ({stat_updates, stat_mispred} !== {eu, em}) begin
            n_fail++;
            $display("FAIL stats: got %0d/%0d want %0d/%0d", stat_updates, stat_mispred, eu, em);
        end
    endtask

    initial begin
        test_reset;
        test_train;
        test_same_cycle;
        test_alias;
        test_saturate;
        test_sweep;
        test_back_to_back;
        test_async_reset;
        test_stats;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
